wb_arb2: RTL and testbench

WB_ARB2 -- requirements
Module: wb_arb2

---
 rtl/wb_arb2_if.sv | 13 +
 rtl/wb_arb2.sv | 59 +++++
 tb/tb_wb_arb2.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/wb_arb2_if.sv
// wb_arb2_if: Wishbone bus bundle shared by requesters and the downstream resource
interface if_wb #(parameter int AWIDTH = 32);
    logic [AWIDTH-1:0] adr;
    logic [31:0] dat_o;
    logic [31:0] dat_i;
    logic [3:0] sel;
    logic we;
    logic cyc;
    logic stb;
    logic ack;
    modport master(output adr, dat_o, sel, we, cyc, stb, input dat_i, ack);
    modport slave(input adr, dat_o, sel, we, cyc, stb, output dat_i, ack);
endinterface

// File: rtl/wb_arb2.sv
// wb_arb2: two-requester round-robin Wishbone arbiter with stall timeout
module wb_arb2 #(
    parameter int TIMEOUT = 255,
    parameter int AWIDTH = 32
) (
    input  logic       clk_i,
    input  logic       rst_i,
    if_wb.slave        m0,
    if_wb.slave        m1,
    if_wb.master       s,
    output logic [1:0] grant,
    output logic       timeout
);
    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] OWN0 = 2'b01;
    localparam logic [1:0] OWN1 = 2'b10;
    localparam logic [7:0] LIM = 8'(TIMEOUT - 1);
    logic [1:0] nxt;
    logic       last;
    logic [7:0] cnt;
    logic       o0;
    logic       o1;
    logic       own_cyc;
    logic       own_stb;
    logic       busy;
    assign o0 = grant == OWN0;
    assign o1 = grant == OWN1;
    assign own_cyc = o0 ? m0.cyc : o1 ? m1.cyc : 1'b0;
    assign own_stb = o0 ? m0.stb : o1 ? m1.stb : 1'b0;
    assign busy = own_cyc & own_stb & ~s.ack;
    assign timeout = busy & (cnt == LIM);
    // an owner still holding cyc always stays; last=1 means m1 was served last
    assign nxt = (o0 & m0.cyc) ? OWN0 :
                 (o1 & m1.cyc) ? OWN1 :
                 (m0.cyc & m1.cyc) ? (last ? OWN0 : OWN1) :
                 m0.cyc ? OWN0 :
                 m1.cyc ? OWN1 : IDLE;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            grant <= IDLE;
            last  <= 1'b1;
            cnt   <= 8'd0;
        end else begin
            grant <= nxt;
            if (nxt != grant && nxt != IDLE) last <= nxt == OWN1;
            cnt <= (nxt != grant || !busy || timeout) ? 8'd0 : cnt + 8'd1;
        end
    end
    assign s.adr   = o0 ? m0.adr : o1 ? m1.adr : {AWIDTH{1'b0}};
    assign s.dat_o = o0 ? m0.dat_o : o1 ? m1.dat_o : 32'h0;
    assign s.sel   = o0 ? m0.sel : o1 ? m1.sel : 4'h0;
    assign s.we    = o0 ? m0.we : o1 ? m1.we : 1'b0;
    assign s.cyc   = own_cyc;
    assign s.stb   = own_stb & ~timeout;
    assign m0.ack   = o0 & (s.ack | timeout);
    assign m1.ack   = o1 & (s.ack | timeout);
    assign m0.dat_i = o0 ? (timeout ? 32'hFFFF_FFFF : s.dat_i) : 32'h0;
    assign m1.dat_i = o1 ? (timeout ? 32'hFFFF_FFFF : s.dat_i) : 32'h0;
endmodule

// File: tb/tb_wb_arb2.sv
// tb_wb_arb2: directed scenarios checked against a behavioural arbiter model every cycle
module tb_wb_arb2;
    localparam int TMO = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic go = 1'b0;
    logic [1:0] grant;
    logic timeout;
    int checks = 0;
    int errors = 0;
    int own = -1;
    int pref = 0;
    int stall = 0;
    if_wb #(.AWIDTH(32)) m0_bus();
    if_wb #(.AWIDTH(32)) m1_bus();
    if_wb #(.AWIDTH(32)) s_bus();
    wb_arb2 #(.TIMEOUT(TMO), .AWIDTH(32)) dut (
        .clk_i(clk), .rst_i(rst), .m0(m0_bus), .m1(m1_bus), .s(s_bus),
        .grant(grant), .timeout(timeout)
    );
    always #5 clk = ~clk;

    function automatic logic mcyc(int i);
        return i == 1 ? m1_bus.cyc : m0_bus.cyc;
    endfunction
    function automatic logic mstb(int i);
        return i == 1 ? m1_bus.stb : m0_bus.stb;
    endfunction
    function automatic logic mwe(int i);
        return i == 1 ? m1_bus.we : m0_bus.we;
    endfunction
    function automatic logic [31:0] madr(int i);
        return i == 1 ? m1_bus.adr : m0_bus.adr;
    endfunction
    function automatic logic [31:0] mdat(int i);
        return i == 1 ? m1_bus.dat_o : m0_bus.dat_o;
    endfunction
    function automatic logic [3:0] msel(int i);
        return i == 1 ? m1_bus.sel : m0_bus.sel;
    endfunction
    function automatic logic stalling();
        return own >= 0 && mcyc(own) && mstb(own) && !s_bus.ack;
    endfunction
    function automatic logic exp_to();
        return stalling() && stall == TMO - 1;
    endfunction
    function automatic int model_next();
        if (own >= 0 && mcyc(own)) return own;
        if (m0_bus.cyc && m1_bus.cyc) return pref;
        if (m0_bus.cyc) return 0;
        if (m1_bus.cyc) return 1;
        return -1;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            own <= -1;
            pref <= 0;
            stall <= 0;
        end else begin
            own <= model_next();
            if (model_next() >= 0 && model_next() != own) pref <= 1 - model_next();
            stall <= (model_next() == own && stalling() && !exp_to()) ? stall + 1 : 0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (go) begin
            chk("grant", 32'(grant), own < 0 ? 32'd0 : own == 0 ? 32'd1 : 32'd2);
            chk("timeout", 32'(timeout), 32'(exp_to()));
            chk("s_cyc", 32'(s_bus.cyc), own < 0 ? 32'd0 : 32'(mcyc(own)));
            chk("s_stb", 32'(s_bus.stb), own < 0 ? 32'd0 : 32'(mstb(own) && !exp_to()));
            chk("s_we", 32'(s_bus.we), own < 0 ? 32'd0 : 32'(mwe(own)));
            chk("s_adr", s_bus.adr, own < 0 ? 32'd0 : madr(own));
            chk("s_dat_o", s_bus.dat_o, own < 0 ? 32'd0 : mdat(own));
            chk("s_sel", 32'(s_bus.sel), own < 0 ? 32'd0 : 32'(msel(own)));
            chk("m0_ack", 32'(m0_bus.ack), 32'(own == 0 && (s_bus.ack || exp_to())));
            chk("m1_ack", 32'(m1_bus.ack), 32'(own == 1 && (s_bus.ack || exp_to())));
            chk("m0_dat_i", m0_bus.dat_i, own == 0 ? (exp_to() ? 32'hFFFF_FFFF : s_bus.dat_i) : 32'd0);
            chk("m1_dat_i", m1_bus.dat_i, own == 1 ? (exp_to() ? 32'hFFFF_FFFF : s_bus.dat_i) : 32'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask
    task automatic neg();
        @(negedge clk);
    endtask
    task automatic req(input int i, input logic on, input logic [31:0] a);
        if (i == 0) begin
            m0_bus.cyc = on; m0_bus.stb = on; m0_bus.adr = a;
        end else begin
            m1_bus.cyc = on; m1_bus.stb = on; m1_bus.adr = a;
        end
    endtask
    task automatic pulse_rst();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        m0_bus.adr = '0; m0_bus.dat_o = 32'h0000_00A0; m0_bus.sel = 4'hF; m0_bus.we = 1'b1;
        m0_bus.cyc = 1'b0; m0_bus.stb = 1'b0;
        m1_bus.adr = '0; m1_bus.dat_o = 32'h0000_00B1; m1_bus.sel = 4'h3; m1_bus.we = 1'b0;
        m1_bus.cyc = 1'b0; m1_bus.stb = 1'b0;
        s_bus.ack = 1'b0; s_bus.dat_i = 32'h0;
        tick(); tick();
        go = 1'b1; rst = 1'b0;
        neg(); chk("rst_grant", 32'(grant), 32'd0); chk("rst_s_sel", 32'(s_bus.sel), 32'd0);
        // single requester
        tick(); req(0, 1, 32'hC000_0010);
        neg(); chk("s1_lat_grant", 32'(grant), 32'd0); chk("s1_lat_cyc", 32'(s_bus.cyc), 32'd0);
        tick(); neg(); chk("s1_grant", 32'(grant), 32'd1); chk("s1_adr", s_bus.adr, 32'hC000_0010);
        tick();
        tick(); s_bus.ack = 1'b1; s_bus.dat_i = 32'h1234_5678;
        neg(); chk("s1_ack", 32'(m0_bus.ack), 32'd1); chk("s1_dat", m0_bus.dat_i, 32'h1234_5678);
        chk("s1_m1_ack", 32'(m1_bus.ack), 32'd0);
        tick(); s_bus.ack = 1'b0; req(0, 0, 32'h0);
        tick(); neg(); chk("s1_idle", 32'(grant), 32'd0);
        // contention after reset
        tick(); pulse_rst();
        req(0, 1, 32'h0000_0A00); req(1, 1, 32'h0000_0B00);
        tick(); s_bus.ack = 1'b1; s_bus.dat_i = 32'h0000_1111;
        neg(); chk("s2_first", 32'(grant), 32'd1); chk("s2_m1_noack", 32'(m1_bus.ack), 32'd0);
        tick(); s_bus.ack = 1'b0; req(0, 0, 32'h0);
        neg(); chk("s2_hold", 32'(grant), 32'd1);
        tick(); s_bus.ack = 1'b1;
        neg(); chk("s2_handoff", 32'(grant), 32'd2); chk("s2_adr", s_bus.adr, 32'h0000_0B00);
        tick(); s_bus.ack = 1'b0; req(1, 0, 32'h0);
        tick(); neg(); chk("s2_idle", 32'(grant), 32'd0);
        req(0, 1, 32'h0000_0A04); req(1, 1, 32'h0000_0B04);
        tick(); neg(); chk("s2_rr", 32'(grant), 32'd1);
        m0_bus.cyc = 1'b0; m1_bus.cyc = 1'b0; m1_bus.stb = 1'b0;
        neg(); chk("s2_abort_ack", 32'(m0_bus.ack), 32'd0);
        tick(); m0_bus.stb = 1'b0;
        neg(); chk("s2_abort_idle", 32'(grant), 32'd0);
        // no preemption during an m1 burst
        tick(); req(1, 1, 32'h0000_2000);
        tick(); s_bus.ack = 1'b1; s_bus.dat_i = 32'h0000_0001;
        neg(); chk("s3_grant", 32'(grant), 32'd2);
        tick(); req(0, 1, 32'h0000_3000); s_bus.dat_i = 32'h0000_0002;
        tick(); s_bus.dat_i = 32'h0000_0003;
        neg(); chk("s3_keep", 32'(grant), 32'd2); chk("s3_m0_noack", 32'(m0_bus.ack), 32'd0);
        chk("s3_m1_ack", 32'(m1_bus.ack), 32'd1); chk("s3_adr", s_bus.adr, 32'h0000_2000);
        tick(); s_bus.dat_i = 32'h0000_0004;
        tick(); s_bus.ack = 1'b0; req(1, 0, 32'h0);
        neg(); chk("s3_tail", 32'(grant), 32'd2);
        tick(); neg(); chk("s3_m0_grant", 32'(grant), 32'd1); chk("s3_m0_adr", s_bus.adr, 32'h0000_3000);
        req(0, 0, 32'h0);
        tick(); tick();
        // timeout with a silent slave
        req(0, 1, 32'h0000_0040);
        tick(); tick(); tick();
        neg(); chk("s4_pre", 32'(timeout), 32'd0);
        tick(); neg();
        chk("s4_ack", 32'(m0_bus.ack), 32'd1); chk("s4_dat", m0_bus.dat_i, 32'hFFFF_FFFF);
        chk("s4_to", 32'(timeout), 32'd1); chk("s4_stb", 32'(s_bus.stb), 32'd0);
        tick(); neg(); chk("s4_pulse", 32'(timeout), 32'd0); chk("s4_noack", 32'(m0_bus.ack), 32'd0);
        req(0, 0, 32'h0);
        tick(); tick();
        // ack arriving on the timeout cycle
        req(0, 1, 32'h0000_0044);
        tick(); tick(); tick();
        tick(); s_bus.ack = 1'b1; s_bus.dat_i = 32'hAAAA_5555;
        neg(); chk("s5_ack", 32'(m0_bus.ack), 32'd1); chk("s5_dat", m0_bus.dat_i, 32'hAAAA_5555);
        chk("s5_to", 32'(timeout), 32'd0); chk("s5_stb", 32'(s_bus.stb), 32'd1);
        tick(); s_bus.ack = 1'b0; req(0, 0, 32'h0);
        tick(); tick();
        // reset while m1 owns
        req(1, 1, 32'h0000_5000);
        tick(); neg(); chk("s6_own", 32'(grant), 32'd2);
        tick(); rst = 1'b1;
        neg(); chk("s6_pre", 32'(grant), 32'd2);
        tick(); rst = 1'b0;
        neg(); chk("s6_grant", 32'(grant), 32'd0); chk("s6_cyc", 32'(s_bus.cyc), 32'd0);
        chk("s6_m1_ack", 32'(m1_bus.ack), 32'd0);
        req(0, 1, 32'h0000_6000);
        tick(); neg(); chk("s6_m0_wins", 32'(grant), 32'd1);
        req(0, 0, 32'h0); req(1, 0, 32'h0);
        tick(); tick();
        go = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
